imm_encoder_loader: RTL and testbench

- Encoder side of the immediate/instruction-format path. Takes decoded fields plus a signed 32-bit immediate and packs them into a 32-bit RV32 instruction word.
- Uses the same itype/jal/jalr format codes as the immediate decode path.
- Streams the packed words into instruction memory through a word-addressed write port.
- Used by the boot/test loader to fill instruction memory.
- Range-checks every immediate; illegal words are dropped and logged.

---
 rtl/imm_encoder_loader.sv | 242 ++++++++++++++++++++++++
 tb/tb_imm_encoder_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder_loader.sv
// imm_encoder_loader: packs decoded RV32 instruction fields plus a signed
// immediate into a 32-bit instruction word. Each session streams these words
// into a word-addressed instruction memory. Bundles whose immediate cannot be
// encoded are dropped and logged.

module imm_encoder_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_end,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_itype,
  input  logic              in_jal,
  input  logic              in_jalr,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              full,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_flag,
  output logic [7:0]        err_count,
  output logic [ADDR_W:0]   err_index
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned ERR_W = 8;
  localparam int unsigned WORD_W = 32;

  // word_count value just before the session's final write
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WORDS - 1);
  localparam logic [ERR_W-1:0] ERR_SAT  = {ERR_W{1'b1}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  localparam logic [2:0] IT_I  = 3'b000;
  localparam logic [2:0] IT_R  = 3'b001;
  localparam logic [2:0] IT_S  = 3'b010;
  localparam logic [2:0] IT_BJ = 3'b110;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [ADDR_W-1:0] ptr;

  logic              accept_c;
  logic              close_c;
  logic              last_c;

  // sign-extension checks for the three immediate widths
  logic              fit_12_c;
  logic              fit_13_c;
  logic              fit_21_c;

  logic [WORD_W-1:0] word_i_c;
  logic [WORD_W-1:0] word_r_c;
  logic [WORD_W-1:0] word_s_c;
  logic [WORD_W-1:0] word_b_c;
  logic [WORD_W-1:0] word_j_c;

  logic              legal_c;
  logic [WORD_W-1:0] word_c;

  // Handshake and session status derived from the state register
  assign in_ready = (state == ST_RUN) & ~load_end & ~load_start;
  assign busy     = (state != ST_IDLE);
  assign full     = (state == ST_FULL);

  assign accept_c = in_valid & in_ready;
  assign close_c  = load_end & ~load_start & (state != ST_IDLE);
  assign last_c   = (word_count == LAST_CNT);

  // An immediate fits an N-bit field when all bits above N-1 copy bit N-1
  always_comb begin
    fit_12_c = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    fit_13_c = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    fit_21_c = (&in_imm[31:20]) | ~(|in_imm[31:20]);
  end

  // Candidate instruction words for every layout
  always_comb begin
    word_i_c = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
    word_r_c = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
    word_s_c = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0],
                in_opcode};
    word_b_c = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                in_imm[4:1], in_imm[11], in_opcode};
    word_j_c = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                in_rd, in_opcode};
  end

  // Layout select and legality; jal takes priority over jalr under 110
  always_comb begin
    legal_c = 1'b0;
    word_c  = '0;
    case (in_itype)
      IT_I: begin
        legal_c = ~in_jal & ~in_jalr & fit_12_c;
        word_c  = word_i_c;
      end
      IT_R: begin
        legal_c = ~in_jal & ~in_jalr;
        word_c  = word_r_c;
      end
      IT_S: begin
        legal_c = ~in_jal & ~in_jalr & fit_12_c;
        word_c  = word_s_c;
      end
      IT_BJ: begin
        if (in_jal) begin
          legal_c = fit_21_c & ~in_imm[0];
          word_c  = word_j_c;
        end else if (in_jalr) begin
          legal_c = fit_12_c;
          word_c  = word_i_c;
        end else begin
          legal_c = fit_13_c & ~in_imm[0];
          word_c  = word_b_c;
        end
      end
      default: begin
        legal_c = 1'b0;
        word_c  = '0;
      end
    endcase
  end

  // Session state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: load_start restarts from any state and beats load_end
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (load_start) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (load_start) begin
          state_next = ST_RUN;
        end else if (load_end) begin
          state_next = ST_IDLE;
        end else if (accept_c & legal_c & last_c) begin
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (load_start) begin
          state_next = ST_RUN;
        end else if (load_end) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Memory write port: one registered write per accepted legal bundle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (accept_c & legal_c) begin
        mem_we    <= 1'b1;
        mem_addr  <= ptr;
        mem_wdata <= word_c;
      end
    end
  end

  // Write pointer and session word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      word_count <= '0;
    end else if (load_start) begin
      ptr        <= load_base;
      word_count <= '0;
    end else if (accept_c & legal_c) begin
      ptr        <= ptr + ADDR_W'(1);
      word_count <= word_count + CNT_W'(1);
    end
  end

  // Rejection log: sticky flag, saturating count, index of first rejection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flag  <= 1'b0;
      err_count <= '0;
      err_index <= '0;
    end else if (load_start) begin
      err_flag  <= 1'b0;
      err_count <= '0;
      err_index <= '0;
    end else if (accept_c & ~legal_c) begin
      err_flag <= 1'b1;
      if (err_count != ERR_SAT) begin
        err_count <= err_count + ERR_W'(1);
      end
      if (!err_flag) begin
        err_index <= word_count;
      end
    end
  end

  // Session-close pulse, one cycle after load_end is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= close_c;
    end
  end

endmodule

// File: tb/tb_imm_encoder_loader.sv
// tb_imm_encoder_loader: directed and randomized bench for imm_encoder_loader
// against an arithmetic reference model of the packing and session rules.

module tb_imm_encoder_loader;

  localparam int unsigned AW    = 10;
  localparam int unsigned MW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic          load_end;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_itype;
  logic          in_jal;
  logic          in_jalr;
  logic [6:0]    in_opcode;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [31:0]   in_imm;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          full;
  logic          done;
  logic [AW:0]   word_count;
  logic          err_flag;
  logic [7:0]    err_count;
  logic [AW:0]   err_index;

  imm_encoder_loader #(.ADDR_W(AW), .MAX_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_base(load_base),
    .load_end(load_end), .in_valid(in_valid), .in_ready(in_ready),
    .in_itype(in_itype), .in_jal(in_jal), .in_jalr(in_jalr),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .full(full), .done(done), .word_count(word_count),
    .err_flag(err_flag), .err_count(err_count), .err_index(err_index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model of the session
  bit          m_open, m_full, m_we, m_done, m_errflag;
  int unsigned m_ptr, m_wc, m_errcnt, m_erridx, m_addr;
  bit [31:0]   m_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Returns {legal, word} using integer range tests and shift/mask packing
  function automatic logic [32:0] ref_encode(
    input logic [2:0] it, input logic j, input logic jr,
    input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [31:0] imm);
    longint    s    = longint'($signed(imm));
    bit [31:0] u    = imm;
    bit [31:0] regs = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    bit [31:0] w    = 0;
    bit        ok   = 0;
    bit        even = (s % 2 == 0);
    if (it == 3'd0 || (it == 3'd6 && jr && !j)) begin
      ok = (it == 3'd6 || (!j && !jr)) && s >= -2048 && s <= 2047;
      w  = ((u & 32'hFFF) << 20) | regs | (32'(rd) << 7);
    end else if (it == 3'd1) begin
      ok = !j && !jr;
      w  = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7);
    end else if (it == 3'd2) begin
      ok = !j && !jr && s >= -2048 && s <= 2047;
      w  = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs | ((u & 32'h1F) << 7);
    end else if (it == 3'd6 && j) begin
      ok = even && s >= -(64'sd1 << 20) && s <= (64'sd1 << 20) - 2;
      w  = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
           (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) |
           (32'(rd) << 7) | 32'(op);
    end else if (it == 3'd6) begin
      ok = even && s >= -4096 && s <= 4094;
      w  = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) |
           (32'(rs2) << 20) | regs | (((u >> 1) & 32'hF) << 8) |
           (((u >> 11) & 1) << 7);
    end
    return {ok, w};
  endfunction

  task automatic model_reset();
    m_open = 0; m_full = 0; m_we = 0; m_done = 0; m_errflag = 0;
    m_ptr = 0; m_wc = 0; m_errcnt = 0; m_erridx = 0; m_addr = 0; m_wdata = 0;
  endtask

  task automatic idle_inputs();
    load_start = 0; load_base = '0; load_end = 0; in_valid = 0;
    in_itype = 0; in_jal = 0; in_jalr = 0; in_opcode = 0; in_funct3 = 0;
    in_funct7 = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
  endtask

  task automatic bundle(input logic [2:0] it, input logic j, input logic jr,
                        input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
    in_valid = 1; in_itype = it; in_jal = j; in_jalr = jr; in_opcode = op;
    in_funct3 = f3; in_funct7 = f7; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm;
  endtask

  task automatic check_outputs();
    check("mem_we",     64'(mem_we),     64'(m_we));
    check("mem_addr",   64'(mem_addr),   64'(m_addr));
    check("mem_wdata",  64'(mem_wdata),  64'(m_wdata));
    check("busy",       64'(busy),       64'(m_open));
    check("full",       64'(full),       64'(m_full));
    check("done",       64'(done),       64'(m_done));
    check("word_count", 64'(word_count), 64'(m_wc));
    check("err_flag",   64'(err_flag),   64'(m_errflag));
    check("err_count",  64'(err_count),  64'(m_errcnt));
    check("err_index",  64'(err_index),  64'(m_erridx));
  endtask

  // One clock with inputs already driven: predict, clock, compare
  task automatic cycle();
    bit          rdy;
    logic [32:0] enc;
    #1;
    rdy = m_open && !m_full && !load_start && !load_end;
    check("in_ready", 64'(in_ready), 64'(rdy));
    m_we = 0; m_done = 0;
    if (load_start) begin
      m_open = 1; m_full = 0; m_ptr = 32'(load_base); m_wc = 0;
      m_errflag = 0; m_errcnt = 0; m_erridx = 0;
    end else if (load_end && m_open) begin
      m_open = 0; m_full = 0; m_done = 1;
    end else if (rdy && in_valid) begin
      enc = ref_encode(in_itype, in_jal, in_jalr, in_opcode, in_funct3,
                       in_funct7, in_rd, in_rs1, in_rs2, in_imm);
      if (enc[32]) begin
        m_we = 1; m_addr = m_ptr; m_wdata = enc[31:0];
        m_ptr = (m_ptr + 1) % DEPTH; m_wc++;
        if (m_wc == MW) m_full = 1;
      end else begin
        if (!m_errflag) m_erridx = m_wc;
        m_errflag = 1;
        if (m_errcnt < 255) m_errcnt++;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic start(input logic [AW-1:0] base);
    idle_inputs(); load_start = 1; load_base = base; cycle(); idle_inputs();
  endtask

  task automatic finish_session();
    idle_inputs(); load_end = 1; cycle(); idle_inputs(); cycle();
  endtask

  int boundary [14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096,
                        -4098, -(1 << 20), (1 << 20) - 2, (1 << 20),
                        -(1 << 20) - 2, -4};

  initial begin
    idle_inputs();
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("reset_ready", 64'(in_ready), 64'(0));
    rst = 0;

    // basic packing, back to back
    start(10'h010);
    bundle(3'b000, 0, 0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    cycle();
    check("addi_word", 64'(mem_wdata), 64'h0000_0000_FFF0_0093);
    check("addi_addr", 64'(mem_addr), 64'h010);
    check("addi_cnt", 64'(word_count), 64'd1);
    bundle(3'b010, 0, 0, 7'h23, 3'd2, 7'd0, 5'd0, 5'd3, 5'd2, 32'd8);
    cycle();
    check("sw_word", 64'(mem_wdata), 64'h0021_A423);
    check("sw_addr", 64'(mem_addr), 64'h011);
    bundle(3'b110, 0, 0, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4);
    cycle();
    check("beq_word", 64'(mem_wdata), 64'hFE00_0EE3);
    bundle(3'b110, 1, 0, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800);
    cycle();
    check("jal_word", 64'(mem_wdata), 64'h0010_00EF);
    check("jal_we", 64'(mem_we), 64'd1);
    check("full_at_max", 64'(full), 64'd1);
    finish_session();

    // rejections
    start(10'h020);
    bundle(3'b000, 0, 0, 7'h13, 3'd0, 7'd0, 5'd2, 5'd1, 5'd0, 32'd5);
    cycle();
    bundle(3'b000, 0, 0, 7'h13, 3'd0, 7'd0, 5'd2, 5'd1, 5'd0, 32'd2048);
    cycle();
    check("rej_i_we", 64'(mem_we), 64'd0);
    bundle(3'b110, 0, 0, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    cycle();
    check("rej_cnt", 64'(err_count), 64'd2);
    check("rej_idx", 64'(err_index), 64'd1);
    check("rej_wc", 64'(word_count), 64'd1);
    finish_session();

    // five bundles into a four-word session
    start(10'h100);
    for (int i = 0; i < 5; i++) begin
      bundle(3'b000, 0, 0, 7'h13, 3'd0, 7'd0, 5'(i), 5'd0, 5'd0, 32'(i));
      cycle();
    end
    check("max_wc", 64'(word_count), 64'd4);
    finish_session();

    // address wrap
    start(10'h3FF);
    bundle(3'b001, 0, 0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd4, 5'd5, 32'd0);
    cycle();
    check("wrap_a0", 64'(mem_addr), 64'h3FF);
    cycle();
    check("wrap_a1", 64'(mem_addr), 64'h000);
    finish_session();

    // restart with a bundle presented alongside load_start
    start(10'h040);
    bundle(3'b000, 0, 0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    cycle();
    load_start = 1; load_base = 10'h050;
    cycle();
    check("restart_we", 64'(mem_we), 64'd0);
    check("restart_wc", 64'(word_count), 64'd0);
    idle_inputs();

    // reset while a write is pending on the port
    bundle(3'b000, 0, 0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
    cycle();
    idle_inputs();
    rst = 1;
    #1;
    model_reset();
    check_outputs();
    check("rst_we", 64'(mem_we), 64'd0);
    @(posedge clk);
    #1;
    rst = 0;
    check_outputs();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int          pick;
      logic [31:0] imm;
      idle_inputs();
      load_start = ($urandom_range(0, 24) == 0);
      load_end   = ($urandom_range(0, 29) == 0);
      load_base  = AW'($urandom);
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1, 2: imm = 32'($signed($urandom_range(0, 80)) - 40);
        3, 4, 5: imm = 32'(boundary[$urandom_range(0, 13)]);
        6:       imm = $urandom;
        default: imm = 32'($signed($urandom_range(0, 1 << 22)) - (1 << 21));
      endcase
      pick = $urandom_range(0, 9);
      bundle((pick < 2) ? 3'b000 : (pick < 4) ? 3'b010 : (pick < 5) ? 3'b001 :
             (pick < 8) ? 3'b110 : 3'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom),
             5'($urandom), 5'($urandom), imm);
      in_valid = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
